// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIPS MEM stage.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 2;

  // MemIn bit positions
  localparam int unsigned MEM_RD = 1;
  localparam int unsigned MEM_WR = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // MEM/WB pipeline register payload
  typedef struct packed {
    logic [CTRL_W-1:0] wb;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  regd;
  } memwb_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface mem_access_stage_if;
  import mem_stage_pkg::*;

  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads either the incoming fields or an all-zero bubble.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load,
  input  memwb_t i_fields,
  output memwb_t o_q
);

  memwb_t r_q;

  // Register update; a bubble clears write-back control and all data fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_fields;
    end else begin
      r_q <= '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: data-memory request FSM, upstream stall and MEM/WB register.
// Optional feature macro: MEM_ALIGN_CHECK_EN (drops misaligned accesses and pulses misaligned).
module mem_access_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CTRL_W-1:0] WBIn,
  input  logic [CTRL_W-1:0] MemIn,
  input  logic [DATA_W-1:0] ALUIn,
  input  logic [DATA_W-1:0] WriteIn,
  input  logic [REG_W-1:0]  RegdIn,
  mem_access_stage_if.master dmem,
  output logic              stall,
  output logic [CTRL_W-1:0] WBOut,
  output logic [DATA_W-1:0] ReadDataOut,
  output logic [DATA_W-1:0] ALUOut,
  output logic [REG_W-1:0]  RegdOut
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misaligned
`endif
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_req;
  logic              r_we;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_access;
  logic              w_is_read;
  logic              w_issue;
  logic              w_done;
  logic              w_load;
  logic [DATA_W-1:0] w_rdata;
  memwb_t            w_fields;
  memwb_t            w_memwb;
`ifdef MEM_ALIGN_CHECK_EN
  logic              w_mis;
  logic              r_mis;
`endif

  assign w_access  = (MemIn != 2'b00);
  // a simultaneous read+write is treated as a write, so it returns no load data
  assign w_is_read = MemIn[MEM_RD] & ~MemIn[MEM_WR];

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall and MEM/WB load selection
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    w_load      = 1'b0;
    w_rdata     = '0;
`ifdef MEM_ALIGN_CHECK_EN
    w_mis       = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (!w_access) begin
          w_load = 1'b1;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (ALUIn[1:0] != 2'b00) begin
          w_mis = 1'b1;
        end
`endif
        else begin
          stall       = 1'b1;
          w_issue     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          w_load      = 1'b1;
          w_done      = 1'b1;
          w_state_nxt = IDLE;
          if (w_is_read) begin
            w_rdata = dmem.dmem_rdata;
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Memory request registers; fields hold for the whole REQ phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_issue) begin
      r_req   <= 1'b1;
      r_we    <= MemIn[MEM_WR];
      r_addr  <= {ALUIn[DATA_W-1:2], 2'b00};
      r_wdata <= WriteIn;
    end else if (w_done) begin
      r_req   <= 1'b0;
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

`ifdef MEM_ALIGN_CHECK_EN
  // Fault pulse aligned with the dropped instruction's MEM/WB bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mis <= 1'b0;
    end else begin
      r_mis <= w_mis;
    end
  end

  assign misaligned = r_mis;
`endif

  assign w_fields = {WBIn, w_rdata, ALUIn, RegdIn};

  mem_wb_reg u_mem_wb_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_fields (w_fields),
    .o_q      (w_memwb)
  );

  assign WBOut       = w_memwb.wb;
  assign ReadDataOut = w_memwb.rdata;
  assign ALUOut      = w_memwb.alu;
  assign RegdOut     = w_memwb.regd;

endmodule
